ex_muldiv_ctrl: RTL and testbench

Sequencer for an iterative RV32M multiply/divide unit attached to the EX stage of the 5-stage pipeline. It accepts an M-extension op together with the forwarded EX operands. It holds the pipeline via a stall request while running 32 radix-2 iterations, then presents the result for one cycle so the EX/MEM register captures it. Hazard logic ORs BusyE into StallF/StallD/StallE and FlushM.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/ex_muldiv_ctrl_if.sv | 23 ++
 rtl/muldiv_datapath.sv | 108 ++++++++++
 rtl/ex_muldiv_ctrl.sv | 116 +++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the EX-stage RV32M multiply/divide sequencer:
// funct3 op codes, FSM state encoding and the special-case result constants.
package riscv_pkg;

    typedef enum logic [2:0] {
        MOP_MUL    = 3'd0,
        MOP_MULH   = 3'd1,
        MOP_MULHSU = 3'd2,
        MOP_MULHU  = 3'd3,
        MOP_DIV    = 3'd4,
        MOP_DIVU   = 3'd5,
        MOP_REM    = 3'd6,
        MOP_REMU   = 3'd7
    } mop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DIV0_Q  = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake/operand bundle between the EX stage (master) and the M unit (slave).
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      MOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            KillE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] MResultE;

    modport master (
        output StartE, MOpE, SrcAE, SrcBE, KillE,
        input  BusyE, DoneE, MResultE
    );

    modport slave (
        input  StartE, MOpE, SrcAE, SrcBE, KillE,
        output BusyE, DoneE, MResultE
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 multiply / restoring divide datapath: operand magnitudes, 64-bit
// accumulator, one step per i_step, sign fixup and result register.
// Accumulator layout: mul -> {partial hi, multiplier lo};
//                     div -> {remainder, dividend/quotient}.
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_fix,
    input  logic            i_spec,
    input  mop_e            i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_spec_val,
    output logic [XLEN-1:0] o_result
);

    mop_e              r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic              w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b;
    logic [XLEN:0]     w_add;
    logic [XLEN:0]     w_rsh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;

    // Operand sign flags depend on the op; unsigned operands never negate.
    assign w_sa    = i_a[XLEN-1] & (i_op inside {MOP_MULH, MOP_MULHSU, MOP_DIV, MOP_REM});
    assign w_sb    = i_b[XLEN-1] & (i_op inside {MOP_MULH, MOP_DIV, MOP_REM});
    assign w_mag_a = w_sa ? -i_a : i_a;
    assign w_mag_b = w_sb ? -i_b : i_b;

    // Shift-add for mul, trial subtract of the shifted remainder for div.
    assign w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    assign w_rsh = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge  = (w_rsh >= {1'b0, r_b});
    assign w_sub = w_rsh[XLEN-1:0] - r_b;   // fits XLEN bits whenever w_ge

    // Next accumulator value for one iteration of the current op.
    always_comb begin
        w_acc_next = r_acc;
        if (r_op[2]) begin
            if (w_ge) w_acc_next = {w_sub, r_acc[XLEN-2:0], 1'b1};
            else      w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
        end else begin
            if (r_acc[0]) w_acc_next = {w_add, r_acc[XLEN-1:1]};
            else          w_acc_next = {1'b0, r_acc[2*XLEN-1:1]};
        end
    end

    assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    // Pick the architectural result half for the latched op.
    always_comb begin
        w_fix_res = '0;
        case (r_op)
            MOP_MUL:                         w_fix_res = w_prod[XLEN-1:0];
            MOP_MULH, MOP_MULHSU, MOP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            MOP_DIV, MOP_DIVU:               w_fix_res = w_quo;
            MOP_REM, MOP_REMU:               w_fix_res = w_rem;
            default:                         w_fix_res = '0;
        endcase
    end

    // Operand latch at start, then one iteration per step.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_op    <= MOP_MUL;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
        end else if (i_load) begin
            r_op    <= i_op;
            r_neg_a <= w_sa;
            r_neg_b <= w_sb;
            r_b     <= w_mag_b;
            r_acc   <= {{XLEN{1'b0}}, w_mag_a};
        end else if (i_step) begin
            r_acc   <= w_acc_next;
        end
    end

    // Result register: written by the special-case shortcut or by fixup, held otherwise.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)       r_result <= '0;
        else if (i_spec) r_result <= i_spec_val;
        else if (i_fix)  r_result <= w_fix_res;
    end

    assign o_result = r_result;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage RV32M sequencer: FSM, iteration counter and special-case
// detection (divide by zero, signed overflow) around muldiv_datapath.
module ex_muldiv_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic                 CLK,
    input  logic                 reset,
    ex_muldiv_ctrl_if.slave      bus
);

    state_e           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;

    mop_e             w_op;
    logic             w_special;
    logic [XLEN-1:0]  w_spec_val;
    logic             w_load, w_spec_ld, w_step, w_fix;
    logic             w_busy, w_done;
    logic [XLEN-1:0]  w_result;

    assign w_op = mop_e'(bus.MOpE);

    // Div/rem results that need no iteration are resolved at start.
    assign w_special = w_op[2] &&
                       ((bus.SrcBE == '0) ||
                        (!w_op[0] && bus.SrcAE == INT_MIN && bus.SrcBE == DIV0_Q));

    assign w_spec_val = (bus.SrcBE == '0) ? (w_op[1] ? bus.SrcAE : DIV0_Q)
                                          : (w_op[1] ? '0 : INT_MIN);

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and control decode; KillE beats every transition out of a busy state.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_spec_ld = 1'b0;
        w_step    = 1'b0;
        w_fix     = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = bus.StartE;
                if (bus.StartE) begin
                    if (w_special) begin
                        w_spec_ld = 1'b1;
                        w_next    = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (bus.KillE) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_busy = 1'b1;
                if (bus.KillE) begin
                    w_next = ST_IDLE;
                end else begin
                    w_fix  = 1'b1;
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = ~bus.KillE;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Iteration counter, cleared at start and advanced once per CALC step.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)       r_cnt <= '0;
        else if (w_load) r_cnt <= '0;
        else if (w_step) r_cnt <= r_cnt + 1'b1;
    end

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_dp (
        .CLK        (CLK),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_fix      (w_fix),
        .i_spec     (w_spec_ld),
        .i_op       (w_op),
        .i_a        (bus.SrcAE),
        .i_b        (bus.SrcBE),
        .i_spec_val (w_spec_val),
        .o_result   (w_result)
    );

    // Stall request must drop the instant reset rises, whatever StartE does.
    assign bus.BusyE    = w_busy & ~reset;
    assign bus.DoneE    = w_done & ~reset;
    assign bus.MResultE = w_result;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: driver pushes expected result and stall
// length into a scoreboard; a negedge monitor checks every DoneE pulse.
module tb_ex_muldiv_ctrl;

    logic CLK = 1'b0;
    logic reset;

    ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

    ex_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Start an op with StartE held until DoneE; operands are scrambled after sampling.
    task automatic run_op(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        exp_t e;
        int   n;
        e.nm = nm; e.res = exp; e.lat = lat;
        sb.push_back(e);
        bus.StartE = 1'b1;
        bus.MOpE   = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        if (bus.DoneE) begin
            @(posedge CLK); #1;      // DONE ignores StartE; sampled in following IDLE
        end
        @(posedge CLK); #1;
        bus.MOpE  = 3'd7;
        bus.SrcAE = 32'hDEADBEEF;
        bus.SrcBE = 32'h00000003;
        n = 0;
        while (!bus.DoneE && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!bus.DoneE) begin
            tests++; fails++;
            $display("FAIL %s_timeout: got no DoneE in 100 cycles, expected DoneE", nm);
        end
        bus.StartE = 1'b0;
    endtask

    // Monitor: count stall cycles, compare result and stall length on each DoneE.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                busy_cnt = 0;
            end else if (bus.DoneE) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got DoneE=1 result=%h, expected no DoneE", bus.MResultE);
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_result"}, bus.MResultE, e.res);
                    chk({e.nm, "_busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
                end
                busy_cnt = 0;
            end else if (bus.BusyE) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin
        reset      = 1'b1;
        bus.StartE = 1'b1;
        bus.MOpE   = 3'd0;
        bus.SrcAE  = 32'd0;
        bus.SrcBE  = 32'd0;
        bus.KillE  = 1'b0;
        #2;
        chk("reset_busy",   32'(bus.BusyE), 32'd0);
        chk("reset_done",   32'(bus.DoneE), 32'd0);
        chk("reset_result", bus.MResultE,   32'd0);
        repeat (2) @(posedge CLK);
        #1;
        bus.StartE = 1'b0;
        reset      = 1'b0;
        @(posedge CLK); #1;

        run_op("mul_7x6",       3'd0, 32'd7,        32'd6,        32'd42,       34);
        run_op("mulh_m1xm1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("mulhu_max",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu_max",    3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("mul_low_wrap",  3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFA, 34);
        run_op("div_m7_2",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        run_op("rem_m7_2",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        run_op("div_7_m2",      3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        run_op("rem_7_m2",      3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
        run_op("divu_min_3",    3'd5, 32'h80000000, 32'd3,        32'h2AAAAAAA, 34);
        run_op("divu_by0",      3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_by0",      3'd7, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        @(posedge CLK); #1;

        // Kill in CALC cycle 10: no result, IDLE rule for BusyE afterwards.
        bus.StartE = 1'b1;
        bus.MOpE   = 3'd0;
        bus.SrcAE  = 32'd3;
        bus.SrcBE  = 32'd5;
        @(posedge CLK);
        repeat (9) @(posedge CLK);
        #1;
        bus.KillE = 1'b1;
        @(posedge CLK); #1;
        bus.KillE  = 1'b0;
        bus.StartE = 1'b0;
        #1;
        chk("kill_busy_idle", 32'(bus.BusyE), 32'd0);
        chk("kill_done_low",  32'(bus.DoneE), 32'd0);
        bus.StartE = 1'b1;
        #1;
        chk("kill_busy_follows_start", 32'(bus.BusyE), 32'd1);
        bus.StartE = 1'b0;
        @(posedge CLK); #1;
        run_op("mul_3x3_after_kill", 3'd0, 32'd3, 32'd3, 32'd9, 34);
        @(posedge CLK); #1;

        // Asynchronous reset while in FIX.
        bus.StartE = 1'b1;
        bus.MOpE   = 3'd5;
        bus.SrcAE  = 32'd100;
        bus.SrcBE  = 32'd7;
        @(posedge CLK);
        repeat (32) @(posedge CLK);
        #1;
        chk("fix_busy", 32'(bus.BusyE), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midfix_reset_busy",   32'(bus.BusyE), 32'd0);
        chk("midfix_reset_done",   32'(bus.DoneE), 32'd0);
        chk("midfix_reset_result", bus.MResultE,   32'd0);
        bus.StartE = 1'b0;
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;
        chk("post_reset_done", 32'(bus.DoneE), 32'd0);

        // Back-to-back: second op sampled in the IDLE right after DONE.
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2,  34);

        repeat (4) @(posedge CLK);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
